uart_rx: RTL and testbench

//   Serial UART receiver, counterpart of the UART transmit path in the peripheral block.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with one-entry holding register and error flags
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OVS     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  input  logic       snum,
  input  logic       rd_en,
  output logic [7:0] d_rx,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overrun
);
  localparam int TW = $clog2((2 * SB_TICK > OVS) ? 2 * SB_TICK : OVS);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] OVS_M1  = TW'(OVS - 1);
  localparam logic [TW-1:0] SB_M1   = TW'(SB_TICK - 1);
  localparam logic [TW-1:0] SB2_M1  = TW'(2 * SB_TICK - 1);
  localparam logic [2:0]    BIT_M1  = 3'(DBIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t          state_q, state_n;
  logic [TW-1:0]   tick_q, tick_n;
  logic [2:0]      bit_q, bit_n;
  logic [DBIT-1:0] shift_q, shift_n;
  logic            snum_q, snum_n, err_q, err_n, ferr_q, ferr_n, fin_n;
  logic            rx_m, rx_s, stop_smp, stop_end, bad;
  // two-flop synchroniser, FSM state and frame-completion strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      snum_q  <= 1'b0;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
      rx_done <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      snum_q  <= snum_n;
      err_q   <= err_n;
      ferr_q  <= ferr_n;
      rx_done <= fin_n;
    end
  end
  assign stop_smp = (tick_q == SB_M1) || (tick_q == SB2_M1);
  assign stop_end = tick_q == (snum_q ? SB2_M1 : SB_M1);
  assign bad      = err_q | (stop_smp & ~rx_s);
  // next-state logic: start validation, mid-bit data sampling, stop-bit checking
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    snum_n  = snum_q;
    err_n   = err_q;
    ferr_n  = ferr_q;
    fin_n   = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_n = START;
        tick_n  = '0;
        snum_n  = snum;
      end
      START: if (s_tick) begin
        if (tick_q == HALF_M1) begin
          state_n = rx_s ? IDLE : DATA;
          tick_n  = '0;
          bit_n   = '0;
        end else tick_n = tick_q + TW'(1);
      end
      DATA: if (s_tick) begin
        if (tick_q == OVS_M1) begin
          shift_n = (shift_q >> 1) | (DBIT'(rx_s) << (DBIT - 1));
          tick_n  = '0;
          state_n = (bit_q == BIT_M1) ? STOP : DATA;
          err_n   = (bit_q == BIT_M1) ? 1'b0 : err_q;
          bit_n   = bit_q + 3'd1;
        end else tick_n = tick_q + TW'(1);
      end
      STOP: if (s_tick) begin
        err_n = bad;
        if (stop_end) begin
          fin_n   = 1'b1;
          ferr_n  = bad;
          tick_n  = '0;
          state_n = bad ? WAIT_HI : IDLE;
        end else tick_n = tick_q + TW'(1);
      end
      WAIT_HI: state_n = rx_s ? IDLE : WAIT_HI;
      default: state_n = IDLE;
    endcase
  end
  // holding register: load on completion when empty or being popped, else flag overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      d_rx      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (rx_done) begin
      if (!rx_valid || rd_en) begin
        d_rx      <= 8'(shift_q);
        frame_err <= ferr_q;
        rx_valid  <= 1'b1;
      end else overrun <= 1'b1;
    end else if (rd_en && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scenario and randomized checks of uart_rx against a frame-level model
module tb_uart_rx;
  logic       clk = 1'b0, reset, s_tick, rx, snum, rd_en;
  logic [7:0] d_rx;
  logic       rx_valid, rx_done, frame_err, overrun;
  int         total = 0, bad = 0, done_cnt = 0, c0;
  logic       m_valid, m_ferr, m_ovr, watch;
  logic [7:0] m_d;
  logic [7:0] got[$];

  uart_rx dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .snum(snum), .rd_en(rd_en),
    .d_rx(d_rx), .rx_valid(rx_valid), .rx_done(rx_done), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    int tdiv;
    tdiv = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv == 2) ? 0 : tdiv + 1;
      s_tick = (tdiv == 2);
    end
  end

  always @(posedge clk) if (rx_done) done_cnt <= done_cnt + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int ns, input logic s1, input logic s2);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(16);
    end
    rx = s1;
    wait_ticks(16);
    if (ns == 2) begin
      rx = s2;
      wait_ticks(16);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  task automatic model_done(input logic [7:0] b, input logic e);
    if (!m_valid) begin
      m_d = b;
      m_ferr = e;
      m_valid = 1'b1;
    end else m_ovr = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; snum = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({d_rx, rx_valid, rx_done, frame_err, overrun} !== 12'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 000", {d_rx, rx_valid, rx_done, frame_err, overrun});
    end
    reset = 1'b0;
    m_valid = 0; m_ferr = 0; m_ovr = 0; m_d = 0;
    idle(20);
  endtask

  task automatic test_basic();
    c0 = done_cnt;
    send_frame(8'hA5, 1, 1'b1, 1'b1);
    idle(8);
    model_done(8'hA5, 1'b0);
    total++; if (done_cnt - c0 !== 1) begin bad++; $display("FAIL basic_done: got %0d want 1", done_cnt - c0); end
    total++; if (d_rx !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", d_rx); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL basic_ferr: got %b want 0", frame_err); end
    pop();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_pop: got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch();
    c0 = done_cnt;
    rx = 1'b0;
    wait_ticks(4);
    idle(30);
    total++; if (done_cnt - c0 !== 0) begin bad++; $display("FAIL glitch_done: got %0d want 0", done_cnt - c0); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
  endtask

  task automatic test_frame_err();
    c0 = done_cnt;
    send_frame(8'h3C, 1, 1'b0, 1'b0);
    wait_ticks(48);
    model_done(8'h3C, 1'b1);
    total++; if (d_rx !== 8'h3C) begin bad++; $display("FAIL ferr_data: got %h want 3c", d_rx); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    total++; if (done_cnt - c0 !== 1) begin bad++; $display("FAIL ferr_break_done: got %0d want 1", done_cnt - c0); end
    idle(40);
    total++; if (done_cnt - c0 !== 1) begin bad++; $display("FAIL ferr_after_high: got %0d want 1", done_cnt - c0); end
    pop();
  endtask

  task automatic test_overrun();
    c0 = done_cnt;
    send_frame(8'h11, 1, 1'b1, 1'b1);
    idle(8);
    send_frame(8'h22, 1, 1'b1, 1'b1);
    idle(8);
    model_done(8'h11, 1'b0);
    model_done(8'h22, 1'b0);
    total++; if (done_cnt - c0 !== 2) begin bad++; $display("FAIL ovr_done: got %0d want 2", done_cnt - c0); end
    total++; if (d_rx !== m_d) begin bad++; $display("FAIL ovr_data: got %h want %h", d_rx, m_d); end
    total++; if (overrun !== m_ovr) begin bad++; $display("FAIL ovr_flag: got %b want %b", overrun, m_ovr); end
    pop();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_pop_valid: got %b want 0", rx_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pop_clear: got %b want 0", overrun); end
  endtask

  task automatic test_two_stop();
    got.delete();
    snum = 1'b1;
    watch = 1'b1;
    fork
      begin
        send_frame(8'h5A, 2, 1'b1, 1'b1);
        send_frame(8'hC3, 2, 1'b1, 1'b1);
        idle(8);
        send_frame(8'h96, 2, 1'b1, 1'b0);
        idle(12);
        watch = 1'b0;
      end
      while (watch) begin
        @(negedge clk);
        if (rx_done) begin
          rd_en = 1'b1;
          @(negedge clk);
          got.push_back(d_rx);
          rd_en = 1'b0;
        end
      end
    join
    snum = 1'b0;
    m_valid = 1'b1; m_d = 8'h96; m_ferr = 1'b1; m_ovr = 1'b0;
    total++; if (got.size() !== 3) begin bad++; $display("FAIL two_stop_count: got %0d want 3", got.size()); end
    else begin
      total++; if (got[0] !== 8'h5A) begin bad++; $display("FAIL two_stop_first: got %h want 5a", got[0]); end
      total++; if (got[1] !== 8'hC3) begin bad++; $display("FAIL two_stop_second: got %h want c3", got[1]); end
      total++; if (got[2] !== 8'h96) begin bad++; $display("FAIL two_stop_third: got %h want 96", got[2]); end
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL two_stop_ovr: got %b want 0", overrun); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL two_stop_ferr: got %b want 1", frame_err); end
  endtask

  task automatic test_reset_mid();
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(48);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({d_rx, rx_valid, rx_done, frame_err, overrun} !== 12'h0) begin
      bad++; $display("FAIL reset_mid_outputs: got %h want 000", {d_rx, rx_valid, rx_done, frame_err, overrun});
    end
    reset = 1'b0;
    m_valid = 0; m_ferr = 0; m_ovr = 0; m_d = 0;
    idle(40);
    c0 = done_cnt;
    send_frame(8'h81, 1, 1'b1, 1'b1);
    idle(8);
    model_done(8'h81, 1'b0);
    total++; if (done_cnt - c0 !== 1) begin bad++; $display("FAIL reset_mid_done: got %0d want 1", done_cnt - c0); end
    total++; if (d_rx !== 8'h81) begin bad++; $display("FAIL reset_mid_data: got %h want 81", d_rx); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_mid_ferr: got %b want 0", frame_err); end
    pop();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic s1, s2, e;
    int ns;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      ns = $urandom_range(1, 2);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      e = !s1 || (ns == 2 && !s2);
      snum = (ns == 2);
      c0 = done_cnt;
      send_frame(b, ns, s1, s2);
      idle(20);
      model_done(b, e);
      total++; if (done_cnt - c0 !== 1) begin bad++; $display("FAIL rand%0d_done: got %0d want 1", k, done_cnt - c0); end
      total++; if (rx_valid !== m_valid) begin bad++; $display("FAIL rand%0d_valid: got %b want %b", k, rx_valid, m_valid); end
      total++; if (d_rx !== m_d) begin bad++; $display("FAIL rand%0d_data: got %h want %h", k, d_rx, m_d); end
      total++; if (frame_err !== m_ferr) begin bad++; $display("FAIL rand%0d_ferr: got %b want %b", k, frame_err, m_ferr); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL rand%0d_ovr: got %b want %b", k, overrun, m_ovr); end
      if ($urandom_range(0, 1) == 1) pop();
    end
    snum = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_two_stop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
